// File: rtl/yuyin_play_ctrl_pkg.sv
// Shared types and helpers for the voice-chip one-wire playback controller.
package yuyin_play_ctrl_pkg;

  // Transmit FSM states for the one-wire serialiser
  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT_HI,
    BIT_LO,
    GAP
  } tx_state_t;

  // Byte sent to the voice chip to halt playback
  localparam logic [7:0] STOP_CODE_DEFAULT = 8'hFE;

  // Width of a down-counter able to hold the longest phase of a frame
  function automatic int cnt_width(input int t_unit, input int start_cycles,
                                   input int gap_cycles);
    int max_v;
    max_v = start_cycles;
    if (gap_cycles > max_v) max_v = gap_cycles;
    if (3 * t_unit > max_v) max_v = 3 * t_unit;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/yuyin_onewire_tx.sv
// One-wire serialiser: start-low pulse, 8 pulse-width coded bits LSB first,
// then a line-high gap before the next frame may begin.
module yuyin_onewire_tx
  import yuyin_play_ctrl_pkg::*;
#(
  parameter int T_UNIT       = 10000,
  parameter int START_CYCLES = 250000,
  parameter int GAP_CYCLES   = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       voice_data,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = cnt_width(T_UNIT, START_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_TWO   = CW'(2);
  localparam logic [CW-1:0] CNT_START = CW'(START_CYCLES);
  localparam logic [CW-1:0] CNT_GAP   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_SHORT = CW'(T_UNIT);
  localparam logic [CW-1:0] CNT_LONG  = CW'(3 * T_UNIT);
  localparam logic          GAP_IS_ONE = (GAP_CYCLES == 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;

  // A new byte is only accepted while the line is idle
  assign tx_ready = (state == IDLE);

  // Frame sequencer: every phase loads the down-counter on entry and advances at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      voice_data <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          voice_data <= 1'b1;
          if (tx_valid) begin
            shreg      <= tx_byte;
            bit_idx    <= '0;
            cnt        <= CNT_START;
            voice_data <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (cnt == CNT_ONE) begin
            bit_idx    <= '0;
            cnt        <= shreg[0] ? CNT_LONG : CNT_SHORT;
            voice_data <= 1'b1;
            state      <= BIT_HI;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        BIT_HI: begin
          if (cnt == CNT_ONE) begin
            cnt        <= shreg[0] ? CNT_SHORT : CNT_LONG;
            voice_data <= 1'b0;
            state      <= BIT_LO;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        BIT_LO: begin
          if (cnt == CNT_ONE) begin
            voice_data <= 1'b1;
            if (bit_idx == 3'd7) begin
              cnt     <= CNT_GAP;
              tx_done <= GAP_IS_ONE;
              state   <= GAP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              cnt     <= shreg[1] ? CNT_LONG : CNT_SHORT;
              state   <= BIT_HI;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        GAP: begin
          voice_data <= 1'b1;
          if (cnt == CNT_ONE) begin
            tx_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt     <= cnt - CNT_ONE;
            tx_done <= (cnt == CNT_TWO);
          end
        end
        default: begin
          voice_data <= 1'b1;
          tx_busy    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/yuyin_play_ctrl.sv
// Voice playback controller: turns decoded voice commands into requests,
// keeps one pending command, and hands bytes to the one-wire serialiser.
module yuyin_play_ctrl
  import yuyin_play_ctrl_pkg::*;
#(
  parameter int         T_UNIT       = 10000,
  parameter int         START_CYCLES = 250000,
  parameter int         GAP_CYCLES   = 500000,
  parameter logic [7:0] STOP_CODE    = STOP_CODE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] yuyin_addr,
  input  logic [1:0] yuyin_one_en,
  output logic       voice_data,
  output logic       tx_busy,
  output logic       tx_done
);

  logic [1:0] en_q;
  logic [6:0] addr_q;
  logic       play_now;
  logic       stop_now;
  logic       slot_valid;
  logic       slot_stop;
  logic [7:0] slot_byte;
  logic       slot_take;
  logic       tx_ready;

  // Play on a rising play bit, or on an address change while play is held
  assign play_now  = yuyin_one_en[0] & (~en_q[0] | (yuyin_addr != addr_q));
  assign stop_now  = yuyin_one_en[1] & ~en_q[1];
  assign slot_take = slot_valid & tx_ready;

  // Previous-cycle copies of the request inputs for edge/change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      addr_q <= '0;
    end else begin
      en_q   <= yuyin_one_en;
      addr_q <= yuyin_addr;
    end
  end

  // One-deep pending slot: newest request wins, but a queued stop is never displaced by a play
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      slot_stop  <= 1'b0;
      slot_byte  <= '0;
    end else if (stop_now) begin
      slot_valid <= 1'b1;
      slot_stop  <= 1'b1;
      slot_byte  <= STOP_CODE;
    end else if (play_now && !(slot_valid && slot_stop && !slot_take)) begin
      slot_valid <= 1'b1;
      slot_stop  <= 1'b0;
      slot_byte  <= {1'b0, yuyin_addr};
    end else if (slot_take) begin
      slot_valid <= 1'b0;
      slot_stop  <= 1'b0;
    end
  end

  yuyin_onewire_tx #(
    .T_UNIT      (T_UNIT),
    .START_CYCLES(START_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_byte   (slot_byte),
    .tx_valid  (slot_valid),
    .tx_ready  (tx_ready),
    .voice_data(voice_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

endmodule

// File: tb/tb_yuyin_play_ctrl.sv
// Scoreboard bench for yuyin_play_ctrl: stimulus pushes expected bytes,
// a line monitor decodes every frame off voice_data and pops/compares.
module tb_yuyin_play_ctrl;

  localparam int T_UNIT       = 4;
  localparam int START_CYCLES = 20;
  localparam int GAP_CYCLES   = 10;

  logic       clk;
  logic       rst_n;
  logic [6:0] yuyin_addr;
  logic [1:0] yuyin_one_en;
  logic       voice_data;
  logic       tx_busy;
  logic       tx_done;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  yuyin_play_ctrl #(
    .T_UNIT      (T_UNIT),
    .START_CYCLES(START_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES),
    .STOP_CODE   (8'hFE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .yuyin_addr  (yuyin_addr),
    .yuyin_one_en(yuyin_one_en),
    .voice_data  (voice_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive the request inputs just after a rising edge
  task automatic applyStimulus(input logic [1:0] en, input logic [6:0] addr);
    @(posedge clk);
    #1;
    yuyin_one_en = en;
    yuyin_addr   = addr;
  endtask

  // Wait until the line is idle and every expected frame has been seen
  task automatic waitIdle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!tx_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("idle_timeout", int'(ok), 1);
  endtask

  // Line monitor states
  typedef enum int {M_IDLE, M_START, M_HI, M_LO, M_GAP} mon_state_t;

  mon_state_t mst = M_IDLE;
  int         run;
  int         hi;
  int         bitn;
  logic [7:0] rx;
  logic       bitv;
  logic       exp_busy;
  logic       exp_done;
  logic [7:0] exp_b;

  // Decode frames off the line at the falling edge and score them
  always @(negedge clk) begin
    if (!rst_n) begin
      mst = M_IDLE;
    end else begin
      exp_busy = (mst != M_IDLE) || (voice_data == 1'b0);
      exp_done = (mst == M_GAP) && (run == GAP_CYCLES - 1);
      checkOutput("tx_busy", int'(tx_busy), int'(exp_busy));
      checkOutput("tx_done", int'(tx_done), int'(exp_done));
      case (mst)
        M_IDLE: begin
          if (!voice_data) begin
            mst  = M_START;
            run  = 1;
            bitn = 0;
            rx   = '0;
          end
        end
        M_START: begin
          if (!voice_data) run++;
          else begin
            checkOutput("start_len", run, START_CYCLES);
            mst = M_HI;
            run = 1;
          end
        end
        M_HI: begin
          if (voice_data) run++;
          else begin
            hi  = run;
            mst = M_LO;
            run = 1;
          end
        end
        M_LO: begin
          if (!voice_data) run++;
          else begin
            bitv = (hi > run);
            checkOutput("bit_period", hi + run, 4 * T_UNIT);
            checkOutput("bit_high", hi, bitv ? 3 * T_UNIT : T_UNIT);
            rx   = {bitv, rx[7:1]};
            bitn++;
            run  = 1;
            mst  = (bitn == 8) ? M_GAP : M_HI;
          end
        end
        M_GAP: begin
          checkOutput("gap_line", int'(voice_data), 1);
          if (exp_done) begin
            checkOutput("frame_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              exp_b = exp_q.pop_front();
              checkOutput("frame_byte", int'(rx), int'(exp_b));
            end
            mst = M_IDLE;
          end else begin
            run++;
          end
        end
        default: mst = M_IDLE;
      endcase
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed stimulus sequence
  initial begin
    bit found;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    yuyin_one_en = 2'b00;
    yuyin_addr   = 7'h00;
    #23;
    checkOutput("reset_voice", int'(voice_data), 1);
    checkOutput("reset_busy", int'(tx_busy), 0);
    checkOutput("reset_done", int'(tx_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Play 0x05 from a rising play bit, with start latency check
    exp_q.push_back(8'h05);
    applyStimulus(2'b01, 7'h05);
    @(posedge clk); #1;
    checkOutput("latency_n1", int'(voice_data), 1);
    @(posedge clk); #1;
    checkOutput("latency_n2", int'(voice_data), 0);
    waitIdle(400);
    applyStimulus(2'b00, 7'h05);
    repeat (5) @(posedge clk);

    // Stop while idle
    exp_q.push_back(8'hFE);
    applyStimulus(2'b10, 7'h05);
    waitIdle(400);
    applyStimulus(2'b00, 7'h05);
    repeat (5) @(posedge clk);

    // Address walk during a frame: only the newest address follows
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h33);
    applyStimulus(2'b01, 7'h05);
    repeat (30) @(posedge clk);
    applyStimulus(2'b01, 7'h12);
    repeat (30) @(posedge clk);
    applyStimulus(2'b01, 7'h33);
    waitIdle(600);
    applyStimulus(2'b00, 7'h33);
    repeat (5) @(posedge clk);

    // Play and stop together mid-frame, then a later play: stop survives
    exp_q.push_back(8'h05);
    exp_q.push_back(8'hFE);
    applyStimulus(2'b01, 7'h05);
    repeat (30) @(posedge clk);
    applyStimulus(2'b11, 7'h06);
    applyStimulus(2'b11, 7'h07);
    applyStimulus(2'b00, 7'h07);
    waitIdle(600);
    repeat (5) @(posedge clk);

    // Request landing in the tx_done cycle starts the next frame two cycles later
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h2A);
    applyStimulus(2'b01, 7'h05);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (tx_done) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("done_seen", int'(found), 1);
    yuyin_addr = 7'h2A;
    @(posedge clk); #1;
    checkOutput("done_req_n1", int'(voice_data), 1);
    @(posedge clk); #1;
    checkOutput("done_req_n2", int'(voice_data), 0);
    waitIdle(600);
    applyStimulus(2'b00, 7'h2A);
    repeat (5) @(posedge clk);

    // Reset in the middle of the first BIT_HI with another play pending
    exp_q.push_back(8'h05);
    applyStimulus(2'b01, 7'h05);
    repeat (2) @(posedge clk);
    applyStimulus(2'b01, 7'h22);
    repeat (23) @(posedge clk);
    #3;
    checkOutput("pre_reset_busy", int'(tx_busy), 1);
    rst_n        = 1'b0;
    yuyin_one_en = 2'b00;
    #1;
    checkOutput("async_voice", int'(voice_data), 1);
    checkOutput("async_busy", int'(tx_busy), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    checkOutput("post_reset_voice", int'(voice_data), 1);
    checkOutput("post_reset_busy", int'(tx_busy), 0);

    // Address toggling with both request bits low is ignored
    for (int i = 0; i < 40; i++) applyStimulus(2'b00, 7'(i * 3 + 1));
    repeat (20) @(posedge clk);
    #1;
    checkOutput("en00_voice", int'(voice_data), 1);
    checkOutput("en00_busy", int'(tx_busy), 0);

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
